gbp_gshare_bpred: RTL and testbench

Parametrised gshare global-history branch predictor, successor to the single-slot global branch predictor.
- Predicts every slot of a multi-instruction fetch block in the frontend, indexed by PC XOR global history.
- Keeps a speculative global history register (GHR) with recovery on mispredict.
- Counter width and history length are configurable.
- Re-initialises the table with a one-row-per-cycle sweep after reset or flush.

---
 rtl/gbp_pkg.sv | 42 ++++
 rtl/gbp_ghr.sv | 37 +++
 rtl/gbp_gshare_bpred.sv | 118 +++++++++++
 tb/tb_gbp_gshare_bpred.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/gbp_pkg.sv
// gbp_pkg: shared types and index/counter helpers for the gshare branch predictor
package gbp_pkg;

    localparam int GBP_PC_W  = 64;
    localparam int GBP_GHR_W = 32;

    typedef struct packed {
        logic valid;
        logic taken;
    } bht_prediction_t;

    typedef struct packed {
        logic                 valid;
        logic [GBP_PC_W-1:0]  pc;
        logic [GBP_GHR_W-1:0] ghr;
        logic                 taken;
        logic                 mispredict;
    } gbp_update_t;

    typedef enum logic {
        INIT,
        RUN
    } gbp_state_e;

    function automatic logic [31:0] gbp_row(input logic [63:0] pc, input logic [31:0] ghr,
                                            input int shift, input int rows);
        return (32'(pc >> shift) ^ ghr) & 32'(rows - 1);
    endfunction

    function automatic logic [31:0] gbp_slot(input logic [63:0] pc, input int offset, input int slots);
        return 32'(pc >> offset) & 32'(slots - 1);
    endfunction

    function automatic logic [7:0] gbp_sat_inc(input logic [7:0] ctr, input int bits);
        return (ctr == 8'((1 << bits) - 1)) ? ctr : ctr + 8'd1;
    endfunction

    function automatic logic [7:0] gbp_sat_dec(input logic [7:0] ctr);
        return (ctr == 8'd0) ? ctr : ctr - 8'd1;
    endfunction

endpackage

// File: rtl/gbp_ghr.sv
// gbp_ghr: speculative global history register with flush, mispredict recovery and push
module gbp_ghr #(
    parameter int GHR_LEN = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               run_i,
    input  logic               debug_mode_i,
    input  logic               spec_push_i,
    input  logic               spec_taken_i,
    input  logic               recover_i,
    input  logic [GHR_LEN-1:0] rec_ghr_i,
    input  logic               rec_taken_i,
    output logic [GHR_LEN-1:0] ghr_o
);

    logic [GHR_LEN-1:0] r_ghr;
    logic [GHR_LEN-1:0] w_ghr_nxt;

    // Recovery beats a same-cycle speculative push; the size cast drops the oldest bit
    always_comb begin
        w_ghr_nxt = flush_i                 ? '0 :
                    (!run_i || debug_mode_i) ? r_ghr :
                    recover_i               ? GHR_LEN'({rec_ghr_i, rec_taken_i}) :
                    spec_push_i             ? GHR_LEN'({r_ghr, spec_taken_i}) : r_ghr;
    end

    // History register with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_ghr <= '0;
        else         r_ghr <= w_ghr_nxt;
    end

    assign ghr_o = r_ghr;

endmodule

// File: rtl/gbp_gshare_bpred.sv
// gbp_gshare_bpred: gshare predictor with per-slot counters, table sweep and speculative GHR
module gbp_gshare_bpred
    import gbp_pkg::*;
#(
    parameter int VLEN            = 64,
    parameter int NR_ENTRIES      = 1024,
    parameter int INSTR_PER_FETCH = 2,
    parameter int CTR_BITS        = 2,
    parameter int GHR_LEN         = 8,
    parameter int RVC             = 1
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   flush_i,
    input  logic                                   debug_mode_i,
    input  logic [VLEN-1:0]                        vpc_i,
    input  logic                                   spec_push_i,
    input  logic                                   spec_taken_i,
    output bht_prediction_t [INSTR_PER_FETCH-1:0]  bht_prediction_o,
    output logic [GHR_LEN-1:0]                     ghr_o,
    output logic                                   ready_o,
    input  logic                                   upd_valid_i,
    input  logic [VLEN-1:0]                        upd_pc_i,
    input  logic [GHR_LEN-1:0]                     upd_ghr_i,
    input  logic                                   upd_taken_i,
    input  logic                                   upd_mispredict_i
);

    localparam int NR_ROWS    = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int INDEX_BITS = $clog2(NR_ROWS);
    localparam int SLOT_W     = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
    localparam int OFFSET     = (RVC != 0) ? 1 : 2;
    localparam int ROW_SHIFT  = OFFSET + $clog2(INSTR_PER_FETCH);
    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    if (GHR_LEN > INDEX_BITS) begin : g_ghr_len_chk
        $error("GHR_LEN must not exceed INDEX_BITS");
    end

    gbp_state_e                                r_state, w_state_nxt;
    logic [INDEX_BITS-1:0]                     r_ptr, w_ptr_nxt;
    logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0]  r_tab [NR_ROWS];
    logic [INSTR_PER_FETCH-1:0][CTR_BITS-1:0]  w_lk_ctrs, w_up_ctrs;
    logic [INDEX_BITS-1:0]                     w_lk_row, w_up_row;
    logic [SLOT_W-1:0]                         w_up_slot;
    logic [CTR_BITS-1:0]                       w_up_new;
    logic [GHR_LEN-1:0]                        w_ghr;
    logic                                      w_run, w_upd_en;
    gbp_update_t                               w_upd;

    assign w_upd     = '{valid: upd_valid_i, pc: GBP_PC_W'(upd_pc_i), ghr: GBP_GHR_W'(upd_ghr_i),
                         taken: upd_taken_i, mispredict: upd_mispredict_i};
    assign w_run     = (r_state == RUN);
    assign w_upd_en  = w_run & w_upd.valid & ~debug_mode_i;
    assign w_lk_row  = INDEX_BITS'(gbp_row(GBP_PC_W'(vpc_i), GBP_GHR_W'(w_ghr), ROW_SHIFT, NR_ROWS));
    assign w_up_row  = INDEX_BITS'(gbp_row(w_upd.pc, w_upd.ghr, ROW_SHIFT, NR_ROWS));
    assign w_up_slot = SLOT_W'(gbp_slot(w_upd.pc, OFFSET, INSTR_PER_FETCH));
    assign w_lk_ctrs = r_tab[w_lk_row];
    assign w_up_ctrs = r_tab[w_up_row];
    assign w_up_new  = w_upd.taken ? CTR_BITS'(gbp_sat_inc(8'(w_up_ctrs[w_up_slot]), CTR_BITS))
                                   : CTR_BITS'(gbp_sat_dec(8'(w_up_ctrs[w_up_slot])));
    assign ready_o   = w_run;

    gbp_ghr #(.GHR_LEN(GHR_LEN)) u_ghr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .run_i        (w_run),
        .debug_mode_i (debug_mode_i),
        .spec_push_i  (spec_push_i),
        .spec_taken_i (spec_taken_i),
        .recover_i    (w_upd.valid & w_upd.mispredict),
        .rec_ghr_i    (w_upd.ghr[GHR_LEN-1:0]),
        .rec_taken_i  (w_upd.taken),
        .ghr_o        (w_ghr)
    );

    assign ghr_o = w_ghr;

    // Sweep one row per cycle in INIT; flush restarts the sweep from row 0
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (flush_i) begin
            w_state_nxt = INIT;
            w_ptr_nxt   = '0;
        end else if (!w_run) begin
            w_state_nxt = (r_ptr == INDEX_BITS'(NR_ROWS - 1)) ? RUN : INIT;
            w_ptr_nxt   = (r_ptr == INDEX_BITS'(NR_ROWS - 1)) ? '0 : r_ptr + 1'b1;
        end
    end

    // FSM state and sweep pointer
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Counter table: sweep writes a whole row, training writes only the addressed slot
    always_ff @(posedge clk_i) begin
        if (!w_run)        r_tab[r_ptr] <= {INSTR_PER_FETCH{INIT_VAL}};
        else if (w_upd_en) r_tab[w_up_row][w_up_slot] <= w_up_new;
    end

    // Zero-latency per-slot prediction from the looked-up row
    always_comb begin
        for (int i = 0; i < INSTR_PER_FETCH; i++) begin
            bht_prediction_o[i].valid = w_run;
            bht_prediction_o[i].taken = w_run & w_lk_ctrs[i][CTR_BITS-1];
        end
    end

endmodule

// File: tb/tb_gbp_gshare_bpred.sv
// tb_gbp_gshare_bpred: directed and random checks of the gshare predictor against a table model
module tb_gbp_gshare_bpred;
    import gbp_pkg::*;

    localparam int ROWS = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_ni, flush_i, debug_mode_i, spec_push_i, spec_taken_i;
    logic                  upd_valid_i, upd_taken_i, upd_mispredict_i, ready_o;
    logic [63:0]           vpc_i, upd_pc_i;
    logic [7:0]            upd_ghr_i, ghr_o;
    bht_prediction_t [1:0] pred;

    gbp_gshare_bpred #(
        .VLEN(64), .NR_ENTRIES(1024), .INSTR_PER_FETCH(2), .CTR_BITS(2), .GHR_LEN(8), .RVC(1)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .debug_mode_i     (debug_mode_i),
        .vpc_i            (vpc_i),
        .spec_push_i      (spec_push_i),
        .spec_taken_i     (spec_taken_i),
        .bht_prediction_o (pred),
        .ghr_o            (ghr_o),
        .ready_o          (ready_o),
        .upd_valid_i      (upd_valid_i),
        .upd_pc_i         (upd_pc_i),
        .upd_ghr_i        (upd_ghr_i),
        .upd_taken_i      (upd_taken_i),
        .upd_mispredict_i (upd_mispredict_i)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: plain counter values, history as an integer, cycles left in the sweep
    int m_ctr [ROWS][2];
    int m_ghr  = 0;
    int m_left = ROWS;
    bit chk_en = 0;

    function automatic int row_of(logic [63:0] pc, int g);
        return int'((pc >> 2) % 64'(ROWS)) ^ g;
    endfunction

    function automatic int slot_of(logic [63:0] pc);
        return int'((pc >> 1) & 64'd1);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare outputs against the model mid-cycle, then advance the model by the inputs the next edge samples
    initial begin
        int r, s, c;
        bit er;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                er = (m_left == 0);
                chk("mdl_ready", ready_o, er);
                chk("mdl_ghr", ghr_o, m_ghr);
                r = row_of(vpc_i, m_ghr);
                for (int k = 0; k < 2; k++) begin
                    chk("mdl_valid", pred[k].valid, er);
                    chk("mdl_taken", pred[k].taken, er && m_ctr[r][k] >= 2);
                end
            end
            if (!rst_ni || flush_i) begin
                m_left = ROWS;
                m_ghr  = 0;
                foreach (m_ctr[i, j]) m_ctr[i][j] = 1;
            end else if (m_left > 0) begin
                m_left--;
            end else if (!debug_mode_i) begin
                if (upd_valid_i) begin
                    r = row_of(upd_pc_i, int'(upd_ghr_i));
                    s = slot_of(upd_pc_i);
                    c = m_ctr[r][s];
                    m_ctr[r][s] = upd_taken_i ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                end
                if (upd_valid_i && upd_mispredict_i) m_ghr = ((int'(upd_ghr_i) * 2) + int'(upd_taken_i)) % 256;
                else if (spec_push_i)                m_ghr = ((m_ghr * 2) + int'(spec_taken_i)) % 256;
            end
            chk_en = 1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [63:0] pc, input logic [7:0] g, input bit t, input bit mis);
        upd_valid_i = 1; upd_pc_i = pc; upd_ghr_i = g; upd_taken_i = t; upd_mispredict_i = mis;
        cyc();
        upd_valid_i = 0; upd_mispredict_i = 0;
    endtask

    task automatic push(input bit t);
        spec_push_i = 1; spec_taken_i = t;
        cyc();
        spec_push_i = 0;
    endtask

    task automatic look(input logic [63:0] pc);
        vpc_i = pc;
        #1;
    endtask

    task automatic wait_ready(inout int n);
        while (!ready_o && n < 2000) begin
            cyc();
            n++;
        end
    endtask

    initial begin
        int n;
        rst_ni = 0; flush_i = 0; debug_mode_i = 0; spec_push_i = 0; spec_taken_i = 0;
        upd_valid_i = 0; upd_taken_i = 0; upd_mispredict_i = 0;
        vpc_i = '0; upd_pc_i = '0; upd_ghr_i = '0;
        cyc(); cyc();
        rst_ni = 1;
        chk("rst_ready", ready_o, 0);
        chk("rst_ghr", ghr_o, 0);
        chk("rst_valid", {pred[1].valid, pred[0].valid}, 0);
        n = 0;
        wait_ready(n);
        chk("init_cycles", n, 512);
        look(64'h100);
        chk("init_pred", pred, 4'b1010);
        chk("init_ghr", ghr_o, 0);

        upd(64'h100, 0, 1, 0);
        look(64'h100);
        chk("sat_up1", pred[0].taken, 1);
        upd(64'h100, 0, 1, 0);
        upd(64'h100, 0, 1, 0);
        chk("sat_up3", pred[0].taken, 1);
        upd(64'h100, 0, 0, 0);
        upd(64'h100, 0, 0, 0);
        chk("sat_dn2", pred[0].taken, 0);
        upd(64'h100, 0, 0, 0);
        upd(64'h100, 0, 0, 0);
        upd(64'h100, 0, 1, 0);
        chk("sat_floor", pred[0].taken, 0);
        chk("sat_slot1", pred[1].taken, 0);

        upd(64'h0, 0, 1, 0);
        upd(64'h0, 0, 1, 0);
        push(1);
        for (int i = 0; i < 6; i++) push(0);
        chk("hash_ghr", ghr_o, 8'h40);
        look(64'h100);
        chk("hash_row0", pred[0].taken, 1);
        push(0); push(0);
        chk("hash_ghr0", ghr_o, 8'h00);
        chk("hash_row40", pred[0].taken, 0);

        push(1); push(1); push(1);
        chk("spec_ghr", ghr_o, 8'h07);
        spec_push_i = 1; spec_taken_i = 1;
        upd(64'h0, 8'h05, 0, 1);
        spec_push_i = 0;
        chk("recover_ghr", ghr_o, 8'h0A);

        upd(64'h100, 0, 1, 0);
        upd(64'h100, 0, 1, 0);
        flush_i = 1;
        cyc();
        flush_i = 0;
        chk("flush_ready", ready_o, 0);
        chk("flush_ghr", ghr_o, 0);
        upd(64'h100, 0, 1, 0);
        upd(64'h100, 0, 1, 0);
        n = 2;
        wait_ready(n);
        chk("flush_cycles", n, 512);
        look(64'h100);
        chk("flush_row", pred[0].taken, 0);

        debug_mode_i = 1;
        spec_push_i = 1; spec_taken_i = 1;
        for (int i = 0; i < 5; i++) upd(64'h100, 0, 1, i == 2);
        spec_push_i = 0;
        chk("dbg_ghr", ghr_o, 0);
        chk("dbg_ctr", pred[0].taken, 0);
        debug_mode_i = 0;
        upd(64'h100, 0, 1, 0);
        chk("dbg_after", pred[0].taken, 1);

        for (int i = 0; i < 4000; i++) begin
            flush_i          = ($urandom_range(0, 599) == 0);
            debug_mode_i     = ($urandom_range(0, 7) == 0);
            spec_push_i      = $urandom_range(0, 1) == 1;
            spec_taken_i     = $urandom_range(0, 1) == 1;
            upd_valid_i      = $urandom_range(0, 1) == 1;
            upd_taken_i      = $urandom_range(0, 2) != 0;
            upd_mispredict_i = ($urandom_range(0, 3) == 0);
            upd_ghr_i        = 8'($urandom);
            upd_pc_i         = (64'($urandom_range(0, 255)) << 1) | (64'($urandom) << 40);
            vpc_i            = (64'($urandom_range(0, 255)) << 1) | (64'($urandom) << 40);
            cyc();
        end
        flush_i = 0; debug_mode_i = 0; spec_push_i = 0; upd_valid_i = 0; upd_mispredict_i = 0;
        cyc(); cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
